// File: rtl/sar_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_pkg
// Description : Shared widths and FSM state encoding for the SAR ADC
//               conversion sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_adc_pkg;

    // Default widths
    localparam int DW           = 8;   // ADC result width
    localparam int AVG_LOG2_MAX = 4;   // up to 16 samples per burst
    localparam int TMR_W        = 16;  // period timer width
    localparam int TO_W         = 12;  // done-timeout counter width

    // Sequencer states
    typedef logic [1:0] sar_state_t;

    localparam sar_state_t c_ST_IDLE  = 2'd0;
    localparam sar_state_t c_ST_START = 2'd1;
    localparam sar_state_t c_ST_REL   = 2'd2;
    localparam sar_state_t c_ST_OUT   = 2'd3;

endpackage : sar_adc_pkg
`default_nettype wire

// File: rtl/sar_adc_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_sync2
// Description : Generic two-flop synchroniser for asynchronous level inputs.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset (output forced to 0)
//               d     - asynchronous input
//               q     - synchronised output, two clk cycles of latency
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sar_adc_sync2
`default_nettype wire

// File: rtl/sar_adc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_seq_ctrl
// Description : Conversion sequencer for the 8-bit SAR ADC macro. Triggers
//               bursts of 2^k conversions from a periodic timer or a software
//               trigger, runs the level start/done handshake, averages the
//               samples and presents the result on a valid/ready interface.
// Ports       : clk, rst_n         - clock, async active-low reset
//               en                 - sequencer enable
//               cfg_period         - timer period in cycles (0 = timer off)
//               cfg_avg_log2       - averaging exponent k (clamped)
//               cfg_timeout        - done timeout in cycles (0 = none)
//               soft_trig          - one-cycle software trigger
//               clr_status         - clears overrun/timeout
//               adc_start/done/data- ADC macro handshake
//               res_data/valid/ready - averaged result, valid/ready
//               busy, overrun, timeout - status
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_seq_ctrl #(
    parameter int DW           = sar_adc_pkg::DW,
    parameter int AVG_LOG2_MAX = sar_adc_pkg::AVG_LOG2_MAX,
    parameter int TMR_W        = sar_adc_pkg::TMR_W,
    parameter int TO_W         = sar_adc_pkg::TO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [TMR_W-1:0] cfg_period,
    input  logic [2:0]       cfg_avg_log2,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             soft_trig,
    input  logic             clr_status,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [DW-1:0]    adc_data,
    output logic [DW-1:0]    res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             overrun,
    output logic             timeout
);

    import sar_adc_pkg::*;

    localparam int       c_SW   = DW + AVG_LOG2_MAX;   // accumulator width
    localparam int       c_CW   = AVG_LOG2_MAX + 1;    // sample counter width
    localparam bit [2:0] c_KMAX = 3'(AVG_LOG2_MAX);

    sar_state_t        r_state;
    sar_state_t        w_state_nxt;
    logic [TMR_W-1:0]  r_tmr;
    logic [TO_W-1:0]   r_to_cnt;
    logic [c_SW-1:0]   r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_k;
    logic              r_abort;
    logic              r_seen_low;
    logic              r_adc_start;
    logic [DW-1:0]     r_res_data;
    logic              r_res_valid;
    logic              r_overrun;
    logic              r_timeout;

    logic              w_done_s;
    logic              w_tmr_run;
    logic              w_tick;
    logic              w_trig;
    logic              w_done_ok;
    logic              w_to_hit;
    logic [2:0]        w_k_cfg;
    logic [c_CW-1:0]   w_target;
    logic [c_SW-1:0]   w_shift;
    logic              w_set_to;
    logic              w_set_ovr;
    logic              w_load;

    sar_adc_sync2 #(
        .WIDTH (1)
    ) u_done_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_done),
        .q     (w_done_s)
    );

    // Timer counts 0..cfg_period-1; the >= compare also recovers cleanly if
    // cfg_period is lowered below the current count.
    assign w_tmr_run = en && (cfg_period != '0);
    assign w_tick    = w_tmr_run && (r_tmr >= (cfg_period - TMR_W'(1)));
    assign w_trig    = (w_tick || soft_trig) && en;

    // A done level already high when START is entered is stale; completion
    // is only accepted after done_s has been seen low inside START.
    assign w_done_ok = w_done_s && r_seen_low;
    assign w_to_hit  = (cfg_timeout != '0) && (r_to_cnt >= (cfg_timeout - TO_W'(1)));

    assign w_k_cfg   = (cfg_avg_log2 > c_KMAX) ? c_KMAX : cfg_avg_log2;
    assign w_target  = c_CW'(1) << r_k;
    assign w_shift   = r_acc >> r_k;

    assign w_set_to  = (r_state == c_ST_START) && en && !w_done_ok && w_to_hit;
    assign w_load    = (r_state == c_ST_OUT) && en && (!r_res_valid || res_ready);
    assign w_set_ovr = (r_state == c_ST_OUT) && en && r_res_valid && !res_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                if (!en || w_done_ok || w_to_hit) begin
                    w_state_nxt = c_ST_REL;
                end
            end
            c_ST_REL: begin
                if (!w_done_s) begin
                    if (r_abort || !en) begin
                        w_state_nxt = c_ST_IDLE;
                    end else if (r_cnt < w_target) begin
                        w_state_nxt = c_ST_START;
                    end else begin
                        w_state_nxt = c_ST_OUT;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_tmr       <= '0;
            r_to_cnt    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_abort     <= 1'b0;
            r_seen_low  <= 1'b0;
            r_adc_start <= 1'b0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_adc_start <= (w_state_nxt == c_ST_START);

            if (!w_tmr_run || w_tick) begin
                r_tmr <= '0;
            end else begin
                r_tmr <= r_tmr + TMR_W'(1);
            end

            if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_trig) begin
                        r_k     <= w_k_cfg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_abort <= 1'b0;
                    end
                end
                c_ST_START: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (!w_done_s) begin
                        r_seen_low <= 1'b1;
                    end
                    if (!en) begin
                        r_abort <= 1'b1;
                    end else if (w_done_ok) begin
                        r_acc <= r_acc + {{AVG_LOG2_MAX{1'b0}}, adc_data};
                        r_cnt <= r_cnt + c_CW'(1);
                    end else if (w_to_hit) begin
                        r_abort <= 1'b1;
                    end
                end
                c_ST_REL: begin
                    if (w_state_nxt == c_ST_IDLE) begin
                        r_acc <= '0;
                    end
                end
                default: begin
                    r_acc <= '0;
                    if (w_load) begin
                        r_res_data  <= w_shift[DW-1:0];
                        r_res_valid <= 1'b1;
                    end
                end
            endcase

            // Every entry into START restarts the timeout and stale-done guard.
            if ((w_state_nxt == c_ST_START) && (r_state != c_ST_START)) begin
                r_to_cnt   <= '0;
                r_seen_low <= 1'b0;
            end

            // Set wins over clear when both occur in the same cycle.
            r_timeout <= w_set_to  || (r_timeout && !clr_status);
            r_overrun <= w_set_ovr || (r_overrun && !clr_status);
        end
    end

    assign adc_start = r_adc_start;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign busy      = (r_state != c_ST_IDLE);
    assign overrun   = r_overrun;
    assign timeout   = r_timeout;

endmodule : sar_adc_seq_ctrl
`default_nettype wire

// File: tb/tb_sar_adc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_adc_seq_ctrl
// Description : Self-checking bench for sar_adc_seq_ctrl with a behavioural
//               ADC macro model and arithmetic reference for averaging.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_adc_seq_ctrl;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic        en           = 1'b0;
    logic [15:0] cfg_period   = '0;
    logic [2:0]  cfg_avg_log2 = '0;
    logic [11:0] cfg_timeout  = '0;
    logic        soft_trig    = 1'b0;
    logic        clr_status   = 1'b0;
    logic        adc_done     = 1'b0;
    logic [7:0]  adc_data     = '0;
    logic        res_ready    = 1'b0;
    logic        adc_start;
    logic [7:0]  res_data;
    logic        res_valid;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    sar_adc_seq_ctrl #(
        .DW           (8),
        .AVG_LOG2_MAX (4),
        .TMR_W        (16),
        .TO_W         (12)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_period   (cfg_period),
        .cfg_avg_log2 (cfg_avg_log2),
        .cfg_timeout  (cfg_timeout),
        .soft_trig    (soft_trig),
        .clr_status   (clr_status),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC macro model: after adc_start rises it waits adc_delay cycles, then
    // raises done with the next queued sample; done drops when start drops.
    int         adc_delay = 10;
    bit         adc_mute  = 1'b0;
    bit         m_busy    = 1'b0;
    bit         m_prev    = 1'b0;
    int         m_cnt     = 0;
    int         start_cnt = 0;
    int         res_cnt   = 0;
    int         fall_cyc  = 0;
    int         done_cyc  = 0;
    int         rise_q[$];
    logic [7:0] smp_q[$];

    always @(negedge clk) begin
        if (res_valid && res_ready) res_cnt++;
        if (adc_start && !m_prev) rise_q.push_back(cyc);
        if (!adc_start && m_prev) fall_cyc = cyc;
        m_prev = adc_start;
        if (!rst_n) begin
            m_busy   = 1'b0;
            adc_done = 1'b0;
        end else if (!m_busy) begin
            if (adc_start && !adc_done) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                start_cnt++;
            end
        end else if (!adc_start) begin
            m_busy   = 1'b0;
            adc_done = 1'b0;
        end else begin
            m_cnt++;
            if (m_cnt == adc_delay && !adc_mute) begin
                if (smp_q.size() > 0) adc_data = smp_q.pop_front();
                else                  adc_data = 8'($urandom);
                adc_done = 1'b1;
                done_cyc = cyc;
            end
        end
    end

    task automatic pulse_trig();
        @(negedge clk);
        soft_trig = 1'b1;
        @(negedge clk);
        soft_trig = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({adc_start, res_valid, busy, overrun, timeout} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000", {adc_start, res_valid, busy, overrun, timeout});
        end
        n_vec++;
        if (res_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got %h want 00", res_data);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({adc_start, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_after_reset: start/busy got %b want 00", {adc_start, busy});
        end
    endtask

    task automatic test_single();
        int s0;
        cfg_avg_log2 = 3'd0;
        res_ready    = 1'b0;
        smp_q.push_back(8'hA5);
        s0 = start_cnt;
        pulse_trig();
        n_vec++;
        if ({adc_start, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL start_latency: start/busy got %b want 11", {adc_start, busy});
        end
        wait_idle(200);
        n_vec++;
        if (start_cnt - s0 != 1) begin
            n_err++;
            $display("FAIL single_starts: got %0d want 1", start_cnt - s0);
        end
        n_vec++;
        if (fall_cyc - done_cyc != 3) begin
            n_err++;
            $display("FAIL done_to_start_drop: got %0d want 3", fall_cyc - done_cyc);
        end
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_result: valid=%b data=%h want 1 a5", res_valid, res_data);
        end
        consume();
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_handshake: valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_averaging();
        int         k, kk, n, s0, sum;
        logic [7:0] smp;
        logic [7:0] exp_res;
        res_ready = 1'b0;
        for (int it = 0; it < 7; it++) begin
            if (it == 0)      k = 2;
            else if (it == 1) k = 4;
            else if (it == 2) k = 7;
            else              k = $urandom_range(0, 7);
            kk  = (k > 4) ? 4 : k;
            n   = 1 << kk;
            sum = 0;
            for (int j = 0; j < n; j++) begin
                if (it == 0)      smp = 8'(10 * (j + 1));
                else if (it == 1) smp = 8'hFF;
                else              smp = 8'($urandom);
                smp_q.push_back(smp);
                sum += smp;
            end
            exp_res      = 8'(sum >> kk);
            cfg_avg_log2 = 3'(k);
            s0           = start_cnt;
            pulse_trig();
            wait_idle(2000);
            n_vec++;
            if (start_cnt - s0 != n) begin
                n_err++;
                $display("FAIL avg_starts[%0d] k=%0d: got %0d want %0d", it, k, start_cnt - s0, n);
            end
            n_vec++;
            if (res_valid !== 1'b1 || res_data !== exp_res) begin
                n_err++;
                $display("FAIL avg_result[%0d] k=%0d: valid=%b data=%0d want 1 %0d", it, k, res_valid, res_data, exp_res);
            end
            consume();
        end
    endtask

    task automatic test_periodic();
        int  s0, r0;
        bit  pulsed;
        cfg_avg_log2 = 3'd0;
        res_ready    = 1'b1;
        rise_q.delete();
        s0     = start_cnt;
        r0     = res_cnt;
        pulsed = 1'b0;
        @(negedge clk);
        cfg_period = 16'd1000;
        for (int i = 0; i < 5050; i++) begin
            @(negedge clk);
            if (busy && !pulsed) begin
                soft_trig = 1'b1;
                pulsed    = 1'b1;
            end else begin
                soft_trig = 1'b0;
            end
        end
        cfg_period = '0;
        wait_idle(200);
        res_ready = 1'b0;
        n_vec++;
        if (res_cnt - r0 != 5 || start_cnt - s0 != 5) begin
            n_err++;
            $display("FAIL periodic_count: results=%0d starts=%0d want 5 5", res_cnt - r0, start_cnt - s0);
        end
        n_vec++;
        if (rise_q.size() != 5) begin
            n_err++;
            $display("FAIL periodic_rises: got %0d want 5", rise_q.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                n_vec++;
                if (rise_q[i] - rise_q[i-1] != 1000) begin
                    n_err++;
                    $display("FAIL periodic_spacing[%0d]: got %0d want 1000", i, rise_q[i] - rise_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] a, b;
        a = 8'($urandom);
        b = a + 8'($urandom_range(1, 255));
        cfg_avg_log2 = 3'd0;
        res_ready    = 1'b0;
        smp_q.push_back(a);
        pulse_trig();
        wait_idle(200);
        smp_q.push_back(b);
        pulse_trig();
        wait_idle(200);
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== a || overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_hold: valid=%b data=%h ovr=%b want 1 %h 1", res_valid, res_data, overrun, a);
        end
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        n_vec++;
        if (overrun !== 1'b0 || res_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_clear: ovr=%b valid=%b want 0 1", overrun, res_valid);
        end
        consume();
        n_vec++;
        if (res_valid !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_drain: valid=%b ovr=%b want 0 0", res_valid, overrun);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] c;
        c            = 8'($urandom);
        cfg_avg_log2 = 3'd0;
        cfg_timeout  = 12'd50;
        res_ready    = 1'b0;
        adc_mute     = 1'b1;
        rise_q.delete();
        pulse_trig();
        wait_idle(300);
        n_vec++;
        if (rise_q.size() != 1) begin
            n_err++;
            $display("FAIL timeout_rises: got %0d want 1", rise_q.size());
        end else begin
            n_vec++;
            if (fall_cyc - rise_q[0] != 50) begin
                n_err++;
                $display("FAIL timeout_width: got %0d want 50", fall_cyc - rise_q[0]);
            end
        end
        n_vec++;
        if (timeout !== 1'b1 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_flag: to=%b valid=%b want 1 0", timeout, res_valid);
        end
        adc_mute = 1'b0;
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        n_vec++;
        if (timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: got %b want 0", timeout);
        end
        smp_q.push_back(c);
        pulse_trig();
        wait_idle(300);
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== c || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_recover: valid=%b data=%h to=%b want 1 %h 0", res_valid, res_data, timeout, c);
        end
        consume();
        cfg_timeout = '0;
    endtask

    task automatic test_abort();
        int         s0, n;
        logic [7:0] d;
        d            = 8'($urandom);
        cfg_avg_log2 = 3'd2;
        res_ready    = 1'b0;
        s0           = start_cnt;
        pulse_trig();
        n = 0;
        while (start_cnt - s0 < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (adc_start !== 1'b0 || start_cnt - s0 != 3) begin
            n_err++;
            $display("FAIL abort_start: start=%b starts=%0d want 0 3", adc_start, start_cnt - s0);
        end
        wait_idle(100);
        n_vec++;
        if (res_valid !== 1'b0 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL abort_result: valid=%b ovr=%b want 0 0", res_valid, overrun);
        end
        en           = 1'b1;
        cfg_avg_log2 = 3'd0;
        smp_q.push_back(d);
        pulse_trig();
        wait_idle(200);
        n_vec++;
        if (res_valid !== 1'b1 || res_data !== d) begin
            n_err++;
            $display("FAIL abort_next: valid=%b data=%h want 1 %h", res_valid, res_data, d);
        end
    endtask

    task automatic test_async_reset();
        cfg_avg_log2 = 3'd0;
        res_ready    = 1'b0;
        pulse_trig();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({adc_start, busy, res_valid} !== 3'b111) begin
            n_err++;
            $display("FAIL pre_reset: start/busy/valid got %b want 111", {adc_start, busy, res_valid});
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({adc_start, busy, res_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset: start/busy/valid got %b want 000", {adc_start, busy, res_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_averaging();
        test_periodic();
        test_overrun();
        test_timeout();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sar_adc_seq_ctrl
`default_nettype wire

// File: doc/sar_adc_seq_ctrl.md
Name: sar_adc_seq_ctrl

Overview:
Conversion sequencer for the 8-bit SAR ADC macro in the user project. Generates start requests from a programmable periodic timer or a software trigger, and runs the level start/done handshake with the macro. Synchronises the macro's done signal, averages 2^k conversions, and presents the result on a valid/ready interface with overrun and timeout status. Sits between the user-project control registers and the ADC macro pins (start, done, data[7:0]).

Parameters:
DW, 8, ADC result width
AVG_LOG2_MAX, 4, maximum averaging exponent (up to 16 samples)
TMR_W, 16, period timer width
TO_W, 12, done-timeout counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  sequencer enable
cfg_period  in  TMR_W  trigger period in clk cycles; 0 = timer off
cfg_avg_log2  in  3  averaging exponent k; values above AVG_LOG2_MAX are clamped
cfg_timeout  in  TO_W  max cycles to wait for done; 0 = no timeout
soft_trig  in  1  one-cycle software trigger
clr_status  in  1  clears overrun and timeout flags
adc_start  out  1  start request to the ADC macro (level)
adc_done  in  1  done from the ADC macro (asynchronous level)
adc_data  in  DW  conversion result; stable while adc_done is high
res_data  out  DW  averaged result
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
busy  out  1  burst in progress
overrun  out  1  sticky: result dropped because the output was still full
timeout  out  1  sticky: done was not seen within cfg_timeout cycles

Behaviour:
- Reset: all outputs 0; timer, accumulator and sample counter 0; FSM in IDLE.
- adc_done passes through a 2-flop synchroniser (done_s). All references to done below mean done_s.
- Timer runs only when en=1 and cfg_period!=0. It counts 0..cfg_period-1 and issues a one-cycle tick when the count equals cfg_period-1, then wraps to 0. When en=0 the timer is held at 0.
- Trigger = (tick | soft_trig) & en. A trigger is accepted only in IDLE; otherwise it is silently ignored.
- FSM states:
  - IDLE: on trigger, latch k = min(cfg_avg_log2, AVG_LOG2_MAX), clear acc and sample count, go to START.
  - START: adc_start=1 and the timeout counter runs. When done=1, add adc_data (zero-extended to DW+AVG_LOG2_MAX) into acc, increment the count, and go to REL. If the timeout counter reaches cfg_timeout first, set timeout and go to REL without accumulating.
  - REL: adc_start=0. Wait for done=0, then:
    - if the burst was aborted by timeout, go to IDLE;
    - if count < 2^k, go to START;
    - otherwise go to OUT.
  - OUT: for one cycle, compute res = acc >> k, then go to IDLE.
    - If res_valid=0 or res_ready=1 that cycle, load res_data and set res_valid.
    - Otherwise drop the new value and set overrun.
- adc_start is registered.
  - Latency: trigger in cycle t gives adc_start=1 at t+1.
  - done high at the pin in cycle d gives adc_start=0 at d+3.
  - res_valid rises 1 cycle after REL exits with the final sample.
- Output handshake: res_valid falls on the cycle after res_valid & res_ready. res_data is held while res_valid=1.
- busy = (state != IDLE).
- en deasserted mid-burst: force adc_start=0 and go to REL. After done=0, go to IDLE with no result, no overrun and acc cleared. A held result stays valid.
- clr_status clears overrun and timeout. If a set event happens in the same cycle, set wins.
- Sum width is DW+AVG_LOG2_MAX, so the maximum 16×255 = 4080 cannot overflow. k=0 gives a pass-through of a single sample.
- done already high when entering START (stale level from the macro) is not accepted as completion. A START entry requires done=0, which REL guarantees.

Decomposition:
- Shared package sar_adc_pkg holds the FSM state enum (IDLE, START, REL, OUT) and the default widths DW, AVG_LOG2_MAX, TMR_W and TO_W.
- Sub-module sar_adc_sync2: generic 2-flop synchroniser with async active-low reset, used for adc_done.
- Timer, FSM, accumulator and output register stay in the top module.

Test Plan:
- Single conversion: k=0, soft_trig, ADC model raises done after 10 cycles with data 0xA5 -> one start pulse; res_data=0xA5, res_valid=1; busy low afterwards.
- Averaging: k=2, samples 10, 20, 30, 40 -> exactly 4 start/done handshakes; res_data=25. With k=4 and all samples 0xFF -> res_data=0xFF (no overflow).
- Periodic: cfg_period=1000, k=0, res_ready tied 1, run 5000 cycles -> 5 results, start rising edges exactly 1000 cycles apart; soft_trig issued while busy is ignored.
- Overrun: res_ready=0, two bursts -> first result held unchanged, overrun=1; clr_status -> overrun=0; res_ready=1 -> handshake completes and res_valid=0.
- Timeout: model never raises done, cfg_timeout=50 -> adc_start drops after 50 cycles, timeout=1, no res_valid, FSM back in IDLE; next trigger proceeds normally.
- Abort and reset: en drops during the 3rd sample of a k=2 burst -> adc_start=0 next cycle, no result. rst_n asserted mid-START -> adc_start, busy and res_valid all 0 immediately (asynchronous).
